// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback formatter: load extraction/extension,
// regfile write port, retire counter. Optional WB_FORWARD_EN adds decode forwarding hits.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              inValid,
  input  logic              inRegWE,
  input  logic [4:0]        inWriteReg,
  input  logic [DATA_W-1:0] inAluResult,
  input  logic [DATA_W-1:0] inMemData,
  input  logic              inMemToReg,
  input  logic [2:0]        inLoadType,
  input  logic [4:0]        reg1,
  input  logic [4:0]        reg2,
  output logic [4:0]        writeReg,
  output logic [DATA_W-1:0] Din,
  output logic              WE,
  output logic              fwd1,
  output logic              fwd2,
  output logic [DATA_W-1:0] fwdData,
  output logic [CNT_W-1:0]  retireCount
);

  typedef struct packed {
    logic              valid;
    logic              regwe;
    logic [4:0]        wr;
    logic [DATA_W-1:0] din;
  } wb_t;

  wb_t               q;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] fmt;

  // Formatting happens ahead of the register so Din is settled for the negedge write.
  always_comb begin
    ld_byte = inMemData[7:0];
    case (inAluResult[1:0])
      2'd1:    ld_byte = inMemData[15:8];
      2'd2:    ld_byte = inMemData[23:16];
      2'd3:    ld_byte = inMemData[31:24];
      default: ld_byte = inMemData[7:0];
    endcase
    ld_half = inAluResult[1] ? inMemData[31:16] : inMemData[15:0];
    fmt = inMemData;
    if (!inMemToReg) fmt = inAluResult;
    else begin
      case (inLoadType)
        3'b001:  fmt = {{24{ld_byte[7]}}, ld_byte};
        3'b010:  fmt = {24'd0, ld_byte};
        3'b011:  fmt = {{16{ld_half[15]}}, ld_half};
        3'b100:  fmt = {16'd0, ld_half};
        default: fmt = inMemData;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      cnt <= '0;
    end else if (flush) begin
      q.valid <= 1'b0;
    end else if (!stall) begin
      q.valid <= inValid;
      q.regwe <= inRegWE;
      q.wr    <= inWriteReg;
      q.din   <= fmt;
      cnt     <= cnt + CNT_W'(inValid);
    end
  end

  assign writeReg    = q.wr;
  assign Din         = q.din;
  assign WE          = q.valid & q.regwe & (q.wr != 5'd0);
  assign retireCount = cnt;

`ifdef WB_FORWARD_EN
  assign fwd1    = WE & (reg1 == q.wr);
  assign fwd2    = WE & (reg2 == q.wr);
  assign fwdData = q.din;
`else
  // Same-cycle RAW is resolved by the regfile's negedge write instead.
  logic unused_fwd;
  assign unused_fwd = ^{reg1, reg2};
  assign fwd1    = 1'b0;
  assign fwd2    = 1'b0;
  assign fwdData = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed load table, stall/flush sequences and a
// randomized run against a spec-level reference model (narrow counter to reach wrap).
module tb_mem_wb_stage;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush, inValid, inRegWE, inMemToReg;
  logic [4:0]  inWriteReg, reg1, reg2, writeReg;
  logic [31:0] inAluResult, inMemData, Din, fwdData;
  logic [2:0]  inLoadType;
  logic        WE, fwd1, fwd2;
  logic [CW-1:0] retireCount;

  mem_wb_stage #(.DATA_W(32), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .inValid(inValid), .inRegWE(inRegWE), .inWriteReg(inWriteReg),
    .inAluResult(inAluResult), .inMemData(inMemData), .inMemToReg(inMemToReg),
    .inLoadType(inLoadType), .reg1(reg1), .reg2(reg2),
    .writeReg(writeReg), .Din(Din), .WE(WE), .fwd1(fwd1), .fwd2(fwd2),
    .fwdData(fwdData), .retireCount(retireCount)
  );

`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  int nvec = 0, nerr = 0;

  // reference state: what the stage holds after the last edge
  bit          m_v, m_we;
  int unsigned m_wr, m_din, m_cnt;

  function automatic int unsigned ref_fmt(int unsigned t, int unsigned a,
                                          int unsigned md, bit m2r);
    int unsigned b, h;
    if (!m2r) return a;
    b = (md >> (8 * (a % 4))) % 256;
    h = (md >> (16 * ((a / 2) % 2))) % 65536;
    case (t)
      1: return (b < 128) ? b : b + 32'hFFFF_FF00;
      2: return b;
      3: return (h < 32768) ? h : h + 32'hFFFF_0000;
      4: return h;
      default: return md;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all();
    bit ewe;
    ewe = m_v && m_we && (m_wr != 0);
    chk("WE", {31'd0, WE}, {31'd0, ewe});
    chk("writeReg", {27'd0, writeReg}, m_wr);
    chk("Din", Din, m_din);
    chk("retireCount", 32'(retireCount), m_cnt);
    chk("fwd1", {31'd0, fwd1}, {31'd0, FWD && ewe && (reg1 == m_wr)});
    chk("fwd2", {31'd0, fwd2}, {31'd0, FWD && ewe && (reg2 == m_wr)});
    chk("fwdData", fwdData, FWD ? m_din : 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_v = 0; m_we = 0; m_wr = 0; m_din = 0; m_cnt = 0;
    end else if (flush) begin
      m_v = 0;
    end else if (!stall) begin
      m_v   = inValid;
      m_we  = inRegWE;
      m_wr  = inWriteReg;
      m_din = ref_fmt(inLoadType, inAluResult, inMemData, inMemToReg);
      if (inValid) m_cnt = (m_cnt + 1) % (1 << CW);
    end
    #1;
    check_all();
  endtask

  typedef struct {
    logic [2:0]  t;
    logic [31:0] a;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[6];

  initial begin
    logic [31:0] hold_din;
    logic [CW-1:0] hold_cnt;

    tbl[0] = '{3'b001, 32'h3, 32'hFFFF_FF80};
    tbl[1] = '{3'b010, 32'h2, 32'h0000_00FF};
    tbl[2] = '{3'b011, 32'h0, 32'h0000_7F01};
    tbl[3] = '{3'b100, 32'h2, 32'h0000_80FF};
    tbl[4] = '{3'b011, 32'h3, 32'hFFFF_80FF};
    tbl[5] = '{3'b111, 32'h1, 32'h80FF_7F01};

    rst = 1; stall = 0; flush = 0; inValid = 0; inRegWE = 0; inMemToReg = 0;
    inWriteReg = 0; inAluResult = 0; inMemData = 0; inLoadType = 0; reg1 = 0; reg2 = 0;
    tick(); tick();
    chk("rst_WE", {31'd0, WE}, 32'd0);
    chk("rst_cnt", 32'(retireCount), 32'd0);
    rst = 0;

    // ALU writeback
    inValid = 1; inRegWE = 1; inWriteReg = 8; inAluResult = 32'h1234_5678; inMemToReg = 0;
    tick();
    chk("alu_Din", Din, 32'h1234_5678);
    chk("alu_WE", {31'd0, WE}, 32'd1);
    chk("alu_cnt", 32'(retireCount), 32'd1);

    // load formatting table
    inMemToReg = 1; inMemData = 32'h80FF_7F01; inWriteReg = 5;
    for (int i = 0; i < 6; i++) begin
      inLoadType = tbl[i].t; inAluResult = tbl[i].a;
      tick();
      chk("load_Din", Din, tbl[i].exp);
    end

    // $0 destination never writes but still retires
    inWriteReg = 0; reg1 = 0; hold_cnt = retireCount;
    tick();
    chk("r0_WE", {31'd0, WE}, 32'd0);
    chk("r0_fwd1", {31'd0, fwd1}, 32'd0);
    chk("r0_cnt", 32'(retireCount), 32'((hold_cnt + 1) % (1 << CW)));

    // stall freeze with changing inputs
    inWriteReg = 12; inMemToReg = 0; inAluResult = 32'hA5A5_0001;
    tick();
    hold_din = Din; hold_cnt = retireCount;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      inAluResult = $urandom; inWriteReg = 5'($urandom_range(1, 31)); inValid = 1;
      tick();
      chk("stall_Din", Din, hold_din);
      chk("stall_cnt", 32'(retireCount), 32'(hold_cnt));
    end
    flush = 1;
    tick();
    chk("flush_WE", {31'd0, WE}, 32'd0);
    chk("flush_cnt", 32'(retireCount), 32'(hold_cnt));
    stall = 0; flush = 0;

    // forwarding
    inValid = 1; inRegWE = 1; inWriteReg = 9; inAluResult = 32'hCAFE_F00D; reg1 = 9; reg2 = 10;
    tick();
    chk("fw_fwd1", {31'd0, fwd1}, {31'd0, FWD});
    chk("fw_fwd2", {31'd0, fwd2}, 32'd0);
    chk("fw_data", fwdData, FWD ? 32'hCAFE_F00D : 32'd0);

    // counter wrap
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < (1 << CW); i++) tick();
    chk("wrap_cnt", 32'(retireCount), 32'd0);

    // randomized run
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 5) == 0);
      inValid = $urandom; inRegWE = $urandom; inMemToReg = $urandom;
      inWriteReg = 5'($urandom_range(0, 7)); inLoadType = 3'($urandom);
      inAluResult = $urandom; inMemData = $urandom;
      reg1 = $urandom_range(0, 1) ? 5'(m_wr) : 5'($urandom_range(0, 7));
      reg2 = 5'($urandom_range(0, 7));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
